// File: rtl/bresenham.sv
// -----------------------------------------------------------------------------
// bresenham
//   Rasterises one line segment (x0,y0)->(x1,y1) using integer Bresenham
//   stepping. The module produces one point per clock into a parallel register
//   bank. Each slot has a valid bit, and a ready flag marks a complete line.
//   Lines with more points than there are slots are truncated. The first
//   P_MAX_LINE_LENGTH points are kept.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_x0, i_x1     start/end x (unsigned, P_X_COORD_W)
//   i_y0, i_y1     start/end y (unsigned, P_Y_COORD_W)
//   i_load_vals    start pulse. Endpoints are sampled on the edge where it is
//                  high. It is accepted in any state, and in RUN it restarts.
//   o_x_vals       slot k at [k*P_X_COORD_W +: P_X_COORD_W]
//   o_y_vals       slot k at [k*P_Y_COORD_W +: P_Y_COORD_W]
//   o_vals_valid   bit k set -> slot k holds a point
//   o_vals_rdy     line complete; slots are stable until the next load
//   o_truncated    (only with BRESENHAM_TRUNC_FLAG_EN) the last slot was
//                  filled before the end point was reached
//
// Optional feature macro: BRESENHAM_TRUNC_FLAG_EN
// -----------------------------------------------------------------------------
module bresenham #(
    parameter int P_MAX_LINE_LENGTH = 10,
    parameter int P_X_COORD_W       = 11,
    parameter int P_Y_COORD_W       = 10
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic [P_X_COORD_W-1:0]                 i_x0,
    input  logic [P_X_COORD_W-1:0]                 i_x1,
    input  logic [P_Y_COORD_W-1:0]                 i_y0,
    input  logic [P_Y_COORD_W-1:0]                 i_y1,
    input  logic                                   i_load_vals,
    output logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0] o_x_vals,
    output logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0] o_y_vals,
    output logic [P_MAX_LINE_LENGTH-1:0]           o_vals_valid,
    output logic                                   o_vals_rdy
`ifdef BRESENHAM_TRUNC_FLAG_EN
    ,
    output logic                                   o_truncated
`endif
);

    // The error term must hold 2*dx and -2*dy without wrapping. One bit
    // covers the doubling and one bit covers the sign.
    localparam int LP_ERR_W = ((P_X_COORD_W > P_Y_COORD_W) ? P_X_COORD_W : P_Y_COORD_W) + 2;
    localparam int LP_K_W   = (P_MAX_LINE_LENGTH > 1) ? $clog2(P_MAX_LINE_LENGTH) : 1;
    localparam logic [LP_K_W-1:0] LP_K_LAST = LP_K_W'(P_MAX_LINE_LENGTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [P_X_COORD_W-1:0]   r_cur_x;
    logic [P_Y_COORD_W-1:0]   r_cur_y;
    logic [P_X_COORD_W-1:0]   r_end_x;
    logic [P_Y_COORD_W-1:0]   r_end_y;
    logic [P_X_COORD_W-1:0]   r_dx;
    logic [P_Y_COORD_W-1:0]   r_dy;
    logic                     r_sx_neg;
    logic                     r_sy_neg;
    logic signed [LP_ERR_W-1:0] r_err;
    logic [LP_K_W-1:0]        r_k;
    logic [P_X_COORD_W-1:0]   r_x_slot [P_MAX_LINE_LENGTH];
    logic [P_Y_COORD_W-1:0]   r_y_slot [P_MAX_LINE_LENGTH];
    logic [P_MAX_LINE_LENGTH-1:0] r_valid;
    logic                     r_rdy;
`ifdef BRESENHAM_TRUNC_FLAG_EN
    logic                     r_trunc;
`endif

    // ---------------------------------------------------------------
    // Load-time setup: absolute deltas, step directions, initial error
    // ---------------------------------------------------------------
    logic                       w_ld_sx_neg;
    logic                       w_ld_sy_neg;
    logic [P_X_COORD_W-1:0]     w_ld_dx;
    logic [P_Y_COORD_W-1:0]     w_ld_dy;
    logic signed [LP_ERR_W-1:0] w_ld_err;

    assign w_ld_sx_neg = (i_x1 < i_x0);
    assign w_ld_sy_neg = (i_y1 < i_y0);
    assign w_ld_dx     = w_ld_sx_neg ? (i_x0 - i_x1) : (i_x1 - i_x0);
    assign w_ld_dy     = w_ld_sy_neg ? (i_y0 - i_y1) : (i_y1 - i_y0);
    assign w_ld_err    = $signed({{(LP_ERR_W-P_X_COORD_W){1'b0}}, w_ld_dx})
                       - $signed({{(LP_ERR_W-P_Y_COORD_W){1'b0}}, w_ld_dy});

    // ---------------------------------------------------------------
    // Per-step Bresenham decision
    // ---------------------------------------------------------------
    logic signed [LP_ERR_W-1:0] w_dx_s;
    logic signed [LP_ERR_W-1:0] w_dy_s;
    logic signed [LP_ERR_W-1:0] w_e2;
    logic                       w_step_x;
    logic                       w_step_y;
    logic signed [LP_ERR_W-1:0] w_err_next;
    logic                       w_at_end;
    logic                       w_last_slot;

    assign w_dx_s      = $signed({{(LP_ERR_W-P_X_COORD_W){1'b0}}, r_dx});
    assign w_dy_s      = $signed({{(LP_ERR_W-P_Y_COORD_W){1'b0}}, r_dy});
    assign w_e2        = r_err + r_err;
    assign w_step_x    = (w_e2 > -w_dy_s);
    assign w_step_y    = (w_e2 < w_dx_s);
    // Both adjustments in the same cycle use the error from before the step.
    assign w_err_next  = r_err - (w_step_x ? w_dy_s : '0) + (w_step_y ? w_dx_s : '0);
    assign w_at_end    = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);
    assign w_last_slot = (r_k == LP_K_LAST);

    // ---------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_end_x  <= '0;
            r_end_y  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_err    <= '0;
            r_k      <= '0;
            r_valid  <= '0;
            r_rdy    <= 1'b0;
            for (int i = 0; i < P_MAX_LINE_LENGTH; i++) begin
                r_x_slot[i] <= '0;
                r_y_slot[i] <= '0;
            end
`ifdef BRESENHAM_TRUNC_FLAG_EN
            r_trunc  <= 1'b0;
`endif
        end else if (i_load_vals) begin
            // A load takes priority in every state, so it also aborts a running line.
            r_state  <= S_RUN;
            r_cur_x  <= i_x0;
            r_cur_y  <= i_y0;
            r_end_x  <= i_x1;
            r_end_y  <= i_y1;
            r_dx     <= w_ld_dx;
            r_dy     <= w_ld_dy;
            r_sx_neg <= w_ld_sx_neg;
            r_sy_neg <= w_ld_sy_neg;
            r_err    <= w_ld_err;
            r_k      <= '0;
            r_valid  <= '0;
            r_rdy    <= 1'b0;
            for (int i = 0; i < P_MAX_LINE_LENGTH; i++) begin
                r_x_slot[i] <= '0;
                r_y_slot[i] <= '0;
            end
`ifdef BRESENHAM_TRUNC_FLAG_EN
            r_trunc  <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < P_MAX_LINE_LENGTH; i++) begin
                if (r_k == LP_K_W'(i)) begin
                    r_x_slot[i] <= r_cur_x;
                    r_y_slot[i] <= r_cur_y;
                    r_valid[i]  <= 1'b1;
                end
            end
            if (w_at_end || w_last_slot) begin
                r_rdy   <= 1'b1;
                r_state <= S_DONE;
`ifdef BRESENHAM_TRUNC_FLAG_EN
                r_trunc <= !w_at_end;
`endif
            end else begin
                r_err <= w_err_next;
                if (w_step_x) begin
                    r_cur_x <= r_sx_neg ? (r_cur_x - 1'b1) : (r_cur_x + 1'b1);
                end
                if (w_step_y) begin
                    r_cur_y <= r_sy_neg ? (r_cur_y - 1'b1) : (r_cur_y + 1'b1);
                end
                r_k <= r_k + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output packing
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < P_MAX_LINE_LENGTH; gi++) begin : g_pack
            assign o_x_vals[gi*P_X_COORD_W +: P_X_COORD_W] = r_x_slot[gi];
            assign o_y_vals[gi*P_Y_COORD_W +: P_Y_COORD_W] = r_y_slot[gi];
        end
    endgenerate

    assign o_vals_valid = r_valid;
    assign o_vals_rdy   = r_rdy;
`ifdef BRESENHAM_TRUNC_FLAG_EN
    assign o_truncated  = r_trunc;
`endif

endmodule

// File: tb/tb_bresenham.sv
// -----------------------------------------------------------------------------
// tb_bresenham
//   Directed-vector bench for bresenham. The expected point lists are
//   hand-computed Bresenham sequences. Each line load prints one summary line.
// -----------------------------------------------------------------------------
module tb_bresenham;

    localparam int N  = 10;
    localparam int XW = 11;
    localparam int YW = 10;

    logic              i_clk;
    logic              i_reset_n;
    logic [XW-1:0]     i_x0, i_x1;
    logic [YW-1:0]     i_y0, i_y1;
    logic              i_load_vals;
    logic [N*XW-1:0]   o_x_vals;
    logic [N*YW-1:0]   o_y_vals;
    logic [N-1:0]      o_vals_valid;
    logic              o_vals_rdy;
`ifdef BRESENHAM_TRUNC_FLAG_EN
    logic              o_truncated;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int exp_x [N];
    int exp_y [N];

    bresenham #(
        .P_MAX_LINE_LENGTH(N),
        .P_X_COORD_W(XW),
        .P_Y_COORD_W(YW)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_x0         (i_x0),
        .i_x1         (i_x1),
        .i_y0         (i_y0),
        .i_y1         (i_y1),
        .i_load_vals  (i_load_vals),
        .o_x_vals     (o_x_vals),
        .o_y_vals     (o_y_vals),
        .o_vals_valid (o_vals_valid),
        .o_vals_rdy   (o_vals_rdy)
`ifdef BRESENHAM_TRUNC_FLAG_EN
        ,
        .o_truncated  (o_truncated)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N*XW-1:0] pack_x(input int n);
        logic [N*XW-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*XW +: XW] = XW'(exp_x[k]);
        return v;
    endfunction

    function automatic logic [N*YW-1:0] pack_y(input int n);
        logic [N*YW-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*YW +: YW] = YW'(exp_y[k]);
        return v;
    endfunction

    // Issue a load and check that the load edge cleared the bank.
    task automatic do_load(input int x0, input int y0, input int x1, input int y1);
        @(negedge i_clk);
        i_x0 = XW'(x0); i_y0 = YW'(y0);
        i_x1 = XW'(x1); i_y1 = YW'(y1);
        i_load_vals = 1'b1;
        @(posedge i_clk);
        #1;
        i_load_vals = 1'b0;
        check("load_clr_valid", 128'(o_vals_valid), 128'(0));
        check("load_clr_rdy",   128'(o_vals_rdy),   128'(0));
    endtask

    // Wait for completion (bounded), then check latency, slots, flags and hold.
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int n, input logic trunc_exp);
        int cycles;
        logic [N*XW-1:0] held_x;
        do_load(x0, y0, x1, y1);
        cycles = 0;
        while (!o_vals_rdy && cycles < 40) begin
            @(posedge i_clk);
            #1;
            cycles++;
        end
        check("latency", 128'(cycles), 128'(n));
        check("valid",   128'(o_vals_valid), 128'((1 << n) - 1));
        check("x_vals",  128'(o_x_vals), 128'(pack_x(n)));
        check("y_vals",  128'(o_y_vals), 128'(pack_y(n)));
`ifdef BRESENHAM_TRUNC_FLAG_EN
        check("truncated", 128'(o_truncated), 128'(trunc_exp));
`else
        if (trunc_exp) begin end
`endif
        // Input changes without a load must not disturb a finished line.
        held_x = pack_x(n);
        i_x0 = XW'($urandom_range(0, 2047)); i_x1 = XW'($urandom_range(0, 2047));
        i_y0 = YW'($urandom_range(0, 1023)); i_y1 = YW'($urandom_range(0, 1023));
        repeat (3) @(posedge i_clk);
        #1;
        check("hold_rdy",   128'(o_vals_rdy), 128'(1));
        check("hold_x",     128'(o_x_vals), 128'(held_x));
        check("hold_valid", 128'(o_vals_valid), 128'((1 << n) - 1));
        $display("line (%0d,%0d)->(%0d,%0d): latency %0d valid 0x%03h", x0, y0, x1, y1, cycles, o_vals_valid);
    endtask

    initial begin
        i_reset_n = 1'b1;
        i_load_vals = 1'b0;
        i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0;
        #2 i_reset_n = 1'b0;
        #3;
        check("rst_x",     128'(o_x_vals),     128'(0));
        check("rst_y",     128'(o_y_vals),     128'(0));
        check("rst_valid", 128'(o_vals_valid), 128'(0));
        check("rst_rdy",   128'(o_vals_rdy),   128'(0));
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("idle_rdy", 128'(o_vals_rdy), 128'(0));

        exp_x = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        exp_y = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        run_line(5, 5, 0, 0, 6, 1'b0);

        exp_x = '{5, 6, 7, 8, 9, 10, 0, 0, 0, 0};
        exp_y = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        run_line(5, 5, 10, 0, 6, 1'b0);

        exp_x = '{5, 5, 4, 4, 3, 3, 0, 0, 0, 0};
        exp_y = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0};
        run_line(5, 5, 3, 0, 6, 1'b0);

        exp_x = '{3, 3, 4, 4, 5, 5, 0, 0, 0, 0};
        exp_y = '{0, 1, 2, 3, 4, 5, 0, 0, 0, 0};
        run_line(3, 0, 5, 5, 6, 1'b0);

        exp_x = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_y = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_line(5, 5, 5, 5, 1, 1'b0);

        exp_x = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_y = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_line(0, 0, 20, 0, 10, 1'b1);

        // Abort: start a long line, then reload a single-point line mid-run.
        do_load(0, 0, 20, 0);
        repeat (3) @(posedge i_clk);
        #1;
        check("abort_pre_valid", 128'(o_vals_valid), 128'(3'b111));
        exp_x = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_y = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_line(5, 5, 5, 5, 1, 1'b0);

        // Asynchronous reset in the middle of a run.
        do_load(0, 0, 20, 0);
        repeat (3) @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_valid", 128'(o_vals_valid), 128'(0));
        check("arst_x",     128'(o_x_vals),     128'(0));
        check("arst_rdy",   128'(o_vals_rdy),   128'(0));
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (12) @(posedge i_clk);
        #1;
        check("post_rst_valid", 128'(o_vals_valid), 128'(0));
        check("post_rst_rdy",   128'(o_vals_rdy),   128'(0));
        $display("reset mid-run: valid 0x%03h rdy %0d", o_vals_valid, o_vals_rdy);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
